seq_div_rem: RTL and testbench

//  Iterative signed divider: the inverse of the multiply-add PE op (p = a*b + c).

---
 rtl/seq_div_rem.sv | 102 ++++++++++
 tb/tb_seq_div_rem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_div_rem.sv
// Iterative signed divider: one restoring-division quotient bit per clock.
// Takes DWIDTH+1 clocks from the accepting edge to the done pulse, whatever the operands.
module seq_div_rem #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [DWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] quotient,
    output logic [DWIDTH-1:0] remainder,
    output logic              div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // CALC  | one unsigned quotient bit per edge, MSB first
    // FIX   | apply operand signs, publish results, pulse done
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    state_t            state;
    logic [DWIDTH-1:0] dvd;
    logic [DWIDTH-1:0] rem;
    logic [DWIDTH-1:0] dsr;
    logic [CW-1:0]     cnt;
    logic              sign_a;
    logic              sign_b;
    logic              zero_b;

    logic [DWIDTH:0]   shifted;
    logic [DWIDTH-1:0] diff;
    logic              take;
    logic [DWIDTH-1:0] mag_a;
    logic [DWIDTH-1:0] mag_b;

    always_comb begin
        shifted = {rem, dvd[DWIDTH-1]};
        take    = (shifted >= {1'b0, dsr});
        diff    = shifted[DWIDTH-1:0] - dsr;
        mag_a   = dividend[DWIDTH-1] ? -dividend : dividend;
        mag_b   = divisor[DWIDTH-1]  ? -divisor  : divisor;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_b      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= mag_a;
                        dsr    <= mag_b;
                        sign_a <= dividend[DWIDTH-1];
                        sign_b <= divisor[DWIDTH-1];
                        zero_b <= (divisor == '0);
                        rem    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem <= take ? diff : shifted[DWIDTH-1:0];
                    dvd <= {dvd[DWIDTH-2:0], take};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DWIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    // With a zero divisor every step subtracts nothing, so rem ends
                    // holding |dividend| and the signed remainder is the dividend itself.
                    quotient    <= zero_b ? '1 : ((sign_a ^ sign_b) ? -dvd : dvd);
                    remainder   <= sign_a ? -rem : rem;
                    div_by_zero <= zero_b;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_rem.sv
// Scoreboard bench for seq_div_rem: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_seq_div_rem;

    localparam int W   = 32;
    localparam int LAT = 33;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_div_rem #(.DWIDTH(W)) dut (
        .clk(clk), .Reset(Reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!Reset && done) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done seen with no operation pending at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", W'(div_by_zero), W'(e.dz));
                check("latency", W'(cyc - e.acc), W'(LAT));
                check("identity", quotient * e.b + remainder, e.a);
            end
        end
    end

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = (b == '0);
        if (dz) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        @(negedge clk);
        while ((busy || Reset) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, k);
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t x;
        issue(a, b);
        x.a = a; x.b = b; x.q = q; x.r = r; x.dz = dz; x.acc = cyc;
        sbq.push_back(x);
    endtask

    task automatic do_rand(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic dz;
        model(a, b, q, r, dz);
        do_op(a, b, q, r, dz);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return MIN;
            1:       return '1;
            2:       return '0;
            3:       return 32'd1;
            4:       return W'($urandom_range(0, 20)) - 32'd10;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_dz", W'(div_by_zero), '0);
        Reset = 1'b0;

        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_op(32'd100, -32'd7, -32'd14, 32'd2, 1'b0);
        do_op(-32'd100, 32'd7, -32'd14, -32'd2, 1'b0);
        do_op(-32'd100, -32'd7, 32'd14, -32'd2, 1'b0);
        do_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        do_op(32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
        do_op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        do_op(MIN, 32'hFFFF_FFFF, MIN, 32'd0, 1'b0);
        do_op(MIN, 32'd1, MIN, 32'd0, 1'b0);
        do_op(32'h7FFF_FFFF, MIN, 32'd0, 32'h7FFF_FFFF, 1'b0);

        // Starts while busy must be ignored; the next op lands in the done cycle.
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        do_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        // Reset in the middle of a calculation discards it.
        issue(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3 Reset = 1'b1;
        #1;
        check("midrst_busy", W'(busy), '0);
        check("midrst_done", W'(done), '0);
        check("midrst_quotient", quotient, '0);
        check("midrst_remainder", remainder, '0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_idle", W'(busy), '0);
        do_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) do_rand(pick(), pick());

        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sbq.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
